// File: rtl/regfile_mp_if.sv
// Request/response bundle for the multi-ported register file.
// The master drives read/write requests; the slave (regfile_mp) returns
// registered read data and the per-port acknowledges.
interface regfile_mp_if #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NUM_RD = 3,
    parameter int NUM_WR = 2
);
    localparam int AW = $clog2(NREGS);

    logic [NUM_RD*AW-1:0]   rd_addr;
    logic [NUM_RD-1:0]      rd_valid;
    logic [NUM_RD*XLEN-1:0] rd_data;
    logic [NUM_RD-1:0]      rd_ack;
    logic [NUM_WR*AW-1:0]   wr_addr;
    logic [NUM_WR*XLEN-1:0] wr_data;
    logic [NUM_WR-1:0]      wr_valid;
    logic [NUM_WR-1:0]      wr_ack;
    logic                   wr_conflict;

    modport master (
        output rd_addr, rd_valid, wr_addr, wr_data, wr_valid,
        input  rd_data, rd_ack, wr_ack, wr_conflict
    );

    modport slave (
        input  rd_addr, rd_valid, wr_addr, wr_data, wr_valid,
        output rd_data, rd_ack, wr_ack, wr_conflict
    );
endinterface

// File: rtl/regfile_mp.sv
// Multi-ported register file: NUM_RD registered read ports, NUM_WR write
// ports, optional hard-wired zero register and optional same-cycle
// write-to-read forwarding. Same-address writes resolve to the highest
// index port and raise a one-cycle conflict pulse.
module regfile_mp #(
    parameter int XLEN    = 32,
    parameter int NREGS   = 32,
    parameter int NUM_RD  = 3,
    parameter int NUM_WR  = 2,
    parameter int ZERO_X0 = 1,
    parameter int BYPASS  = 1
) (
    input logic          clk,
    input logic          reset,
    regfile_mp_if.slave  bus
);
    localparam int AW = $clog2(NREGS);

    // Register array and registered outputs
    logic [XLEN-1:0]        regs_r [NREGS];
    logic [NUM_RD*XLEN-1:0] rd_data_r;
    logic [NUM_RD-1:0]      rd_ack_r;
    logic [NUM_WR-1:0]      wr_ack_r;
    logic                   wr_conflict_r;

    // Unpacked views of the request buses and next-state values
    logic [AW-1:0]          rd_addr_s  [NUM_RD];
    logic [AW-1:0]          wr_addr_s  [NUM_WR];
    logic [XLEN-1:0]        wr_data_s  [NUM_WR];
    logic [NUM_WR-1:0]      wr_live_s;
    logic [XLEN-1:0]        regs_nxt_s [NREGS];
    logic [NUM_RD*XLEN-1:0] rd_data_nxt_s;
    logic                   conflict_s;

    // Address 0 is the hard-wired zero register only when ZERO_X0 is set.
    function automatic logic is_zero_reg(input logic [AW-1:0] addr);
        return (ZERO_X0 != 0) && (addr == {AW{1'b0}});
    endfunction

    // Slice the packed request buses into per-port fields; a write is live
    // only if it will actually modify storage.
    always_comb begin
        for (int i = 0; i < NUM_RD; i++) begin
            rd_addr_s[i] = bus.rd_addr[i*AW +: AW];
        end
        for (int j = 0; j < NUM_WR; j++) begin
            wr_addr_s[j] = bus.wr_addr[j*AW +: AW];
            wr_data_s[j] = bus.wr_data[j*XLEN +: XLEN];
            wr_live_s[j] = bus.wr_valid[j] && !is_zero_reg(bus.wr_addr[j*AW +: AW]);
        end
    end

    // Next register contents: later (higher-index) ports override earlier ones.
    always_comb begin
        for (int k = 0; k < NREGS; k++) begin
            regs_nxt_s[k] = regs_r[k];
            for (int j = 0; j < NUM_WR; j++) begin
                regs_nxt_s[k] = (wr_live_s[j] && (wr_addr_s[j] == AW'(k)))
                              ? wr_data_s[j] : regs_nxt_s[k];
            end
        end
    end

    // Read data selection: zero register, forwarded write data, or stored value.
    always_comb begin
        rd_data_nxt_s = rd_data_r;
        for (int i = 0; i < NUM_RD; i++) begin
            logic [XLEN-1:0] val_s;
            val_s = regs_r[rd_addr_s[i]];
            for (int j = 0; j < NUM_WR; j++) begin
                val_s = ((BYPASS != 0) && bus.wr_valid[j] && (wr_addr_s[j] == rd_addr_s[i]))
                      ? wr_data_s[j] : val_s;
            end
            val_s = is_zero_reg(rd_addr_s[i]) ? {XLEN{1'b0}} : val_s;
            rd_data_nxt_s[i*XLEN +: XLEN] = bus.rd_valid[i] ? val_s : rd_data_r[i*XLEN +: XLEN];
        end
    end

    // Conflict detection over every pair of live writes.
    always_comb begin
        conflict_s = 1'b0;
        for (int j = 0; j < NUM_WR; j++) begin
            for (int m = j + 1; m < NUM_WR; m++) begin
                conflict_s = conflict_s
                           | (wr_live_s[j] && wr_live_s[m] && (wr_addr_s[j] == wr_addr_s[m]));
            end
        end
    end

    // State update; reset wins over any request presented at the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NREGS; k++) begin
                regs_r[k] <= {XLEN{1'b0}};
            end
            rd_data_r     <= {(NUM_RD*XLEN){1'b0}};
            rd_ack_r      <= {NUM_RD{1'b0}};
            wr_ack_r      <= {NUM_WR{1'b0}};
            wr_conflict_r <= 1'b0;
        end else begin
            for (int k = 0; k < NREGS; k++) begin
                regs_r[k] <= regs_nxt_s[k];
            end
            rd_data_r     <= rd_data_nxt_s;
            rd_ack_r      <= bus.rd_valid;
            wr_ack_r      <= bus.wr_valid;
            wr_conflict_r <= conflict_s;
        end
    end

    assign bus.rd_data     = rd_data_r;
    assign bus.rd_ack      = rd_ack_r;
    assign bus.wr_ack      = wr_ack_r;
    assign bus.wr_conflict = wr_conflict_r;
endmodule

// File: tb/tb_regfile_mp.sv
// Directed + random bench for regfile_mp. Two instances share stimulus:
// one with forwarding, one without. Expected values are pushed to a
// scoreboard queue when stimulus is driven and popped after the edge.
module tb_regfile_mp;
    localparam int XLEN   = 32;
    localparam int NREGS  = 32;
    localparam int NUM_RD = 3;
    localparam int NUM_WR = 2;
    localparam int AW     = 5;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    regfile_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR)) bus ();
    regfile_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR)) bus_nb ();

    assign bus_nb.rd_addr  = bus.rd_addr;
    assign bus_nb.rd_valid = bus.rd_valid;
    assign bus_nb.wr_addr  = bus.wr_addr;
    assign bus_nb.wr_data  = bus.wr_data;
    assign bus_nb.wr_valid = bus.wr_valid;

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR),
                 .ZERO_X0(1), .BYPASS(1)) dut (.clk(clk), .reset(reset), .bus(bus));
    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR),
                 .ZERO_X0(1), .BYPASS(0)) dut_nb (.clk(clk), .reset(reset), .bus(bus_nb));

    typedef struct {
        int              kind;
        int              idx;
        logic [XLEN-1:0] exp;
    } sb_t;

    sb_t             sb_q [$];
    int              checks = 0;
    int              errors = 0;
    logic [XLEN-1:0] mdl     [NREGS];
    logic [XLEN-1:0] hold    [NUM_RD];
    logic [XLEN-1:0] hold_nb [NUM_RD];

    function automatic string kname(input int kind, input int idx);
        string s;
        case (kind)
            0: s = "rd_data";
            1: s = "rd_ack";
            2: s = "wr_ack";
            3: s = "wr_conflict";
            4: s = "nb_rd_data";
            5: s = "nb_rd_ack";
            6: s = "nb_wr_ack";
            7: s = "nb_wr_conflict";
            default: s = "unknown";
        endcase
        return $sformatf("%s[%0d]", s, idx);
    endfunction

    function automatic logic [XLEN-1:0] observe(input int kind, input int idx);
        logic [XLEN-1:0] r;
        case (kind)
            0: r = bus.rd_data[idx*XLEN +: XLEN];
            1: r = XLEN'(bus.rd_ack[idx]);
            2: r = XLEN'(bus.wr_ack[idx]);
            3: r = XLEN'(bus.wr_conflict);
            4: r = bus_nb.rd_data[idx*XLEN +: XLEN];
            5: r = XLEN'(bus_nb.rd_ack[idx]);
            6: r = XLEN'(bus_nb.wr_ack[idx]);
            7: r = XLEN'(bus_nb.wr_conflict);
            default: r = {XLEN{1'bx}};
        endcase
        return r;
    endfunction

    task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input int kind, input int idx, input logic [XLEN-1:0] exp);
        sb_t e;
        e.kind = kind;
        e.idx  = idx;
        e.exp  = exp;
        sb_q.push_back(e);
    endtask

    // Drive one cycle of stimulus, predict, clock, then drain the scoreboard.
    task automatic step(input logic rst,
                        input logic [NUM_RD-1:0] rv, input logic [NUM_RD*AW-1:0] ra,
                        input logic [NUM_WR-1:0] wv, input logic [NUM_WR*AW-1:0] wa,
                        input logic [NUM_WR*XLEN-1:0] wd);
        logic [AW-1:0]   a;
        logic [XLEN-1:0] v;
        logic [XLEN-1:0] vnb;
        logic            c;
        sb_t             e;
        @(negedge clk);
        reset        = rst;
        bus.rd_valid = rv;
        bus.rd_addr  = ra;
        bus.wr_valid = wv;
        bus.wr_addr  = wa;
        bus.wr_data  = wd;
        for (int i = 0; i < NUM_RD; i++) begin
            a = ra[i*AW +: AW];
            if (rst) begin
                hold[i]    = '0;
                hold_nb[i] = '0;
                push(1, i, '0);
                push(5, i, '0);
            end else if (rv[i]) begin
                v   = mdl[a];
                vnb = mdl[a];
                for (int j = 0; j < NUM_WR; j++) begin
                    if (wv[j] && wa[j*AW +: AW] == a) v = wd[j*XLEN +: XLEN];
                end
                if (a == 5'd0) begin
                    v   = '0;
                    vnb = '0;
                end
                hold[i]    = v;
                hold_nb[i] = vnb;
                push(1, i, 32'd1);
                push(5, i, 32'd1);
            end else begin
                push(1, i, '0);
                push(5, i, '0);
            end
            push(0, i, hold[i]);
            push(4, i, hold_nb[i]);
        end
        for (int j = 0; j < NUM_WR; j++) begin
            push(2, j, (rst ? 32'd0 : XLEN'(wv[j])));
            push(6, j, (rst ? 32'd0 : XLEN'(wv[j])));
        end
        c = 1'b0;
        for (int j = 0; j < NUM_WR; j++) begin
            for (int m = j + 1; m < NUM_WR; m++) begin
                if (!rst && wv[j] && wv[m] && wa[j*AW +: AW] == wa[m*AW +: AW]
                    && wa[j*AW +: AW] != 5'd0) c = 1'b1;
            end
        end
        push(3, 0, XLEN'(c));
        push(7, 0, XLEN'(c));
        if (rst) begin
            for (int k = 0; k < NREGS; k++) mdl[k] = '0;
        end else begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (wv[j] && wa[j*AW +: AW] != 5'd0) mdl[wa[j*AW +: AW]] = wd[j*XLEN +: XLEN];
            end
        end
        @(posedge clk);
        #1;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check(kname(e.kind, e.idx), observe(e.kind, e.idx), e.exp);
        end
    endtask

    initial begin
        logic [NUM_RD-1:0]      rv;
        logic [NUM_RD*AW-1:0]   ra;
        logic [NUM_WR-1:0]      wv;
        logic [NUM_WR*AW-1:0]   wa;
        logic [NUM_WR*XLEN-1:0] wd;

        for (int k = 0; k < NREGS; k++) mdl[k] = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            hold[i]    = '0;
            hold_nb[i] = '0;
        end
        reset        = 1'b1;
        bus.rd_valid = '0;
        bus.rd_addr  = '0;
        bus.wr_valid = '0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;

        // Reset with a write and read presented: both dropped.
        step(1'b1, 3'b111, {5'd2, 5'd2, 5'd2}, 2'b01, {5'd0, 5'd2}, {32'd0, 32'h1111_2222});
        step(1'b1, 3'b000, 15'd0, 2'b00, 10'd0, 64'd0);
        check("reset_wr_ack", XLEN'(bus.wr_ack), 32'd0);

        // Read reg 5 after reset.
        step(1'b0, 3'b001, {5'd0, 5'd0, 5'd5}, 2'b00, 10'd0, 64'd0);
        check("req018_data", bus.rd_data[31:0], 32'd0);
        check("req018_ack", XLEN'(bus.rd_ack[0]), 32'd1);

        // Write reg 7, then read it on every port.
        step(1'b0, 3'b000, 15'd0, 2'b01, {5'd0, 5'd7}, {32'd0, 32'hDEAD_BEEF});
        check("req019_wr_ack", XLEN'(bus.wr_ack), 32'd1);
        step(1'b0, 3'b111, {5'd7, 5'd7, 5'd7}, 2'b00, 10'd0, 64'd0);
        check("req019_p2", bus.rd_data[95:64], 32'hDEAD_BEEF);
        check("req019_wr_ack_drop", XLEN'(bus.wr_ack), 32'd0);

        // Same-edge write/read of reg 3: forwarded vs old value.
        step(1'b0, 3'b001, {5'd0, 5'd0, 5'd3}, 2'b01, {5'd0, 5'd3}, {32'd0, 32'h0000_1234});
        check("req020_bypass", bus.rd_data[31:0], 32'h0000_1234);
        check("req020_nobypass", bus_nb.rd_data[31:0], 32'd0);

        // Idle cycle: acks drop, data holds.
        step(1'b0, 3'b000, {5'd1, 5'd1, 5'd1}, 2'b00, 10'd0, 64'd0);

        // Two writes to reg 9: port 1 wins, conflict pulse.
        step(1'b0, 3'b000, 15'd0, 2'b11, {5'd9, 5'd9}, {32'h0000_5555, 32'h0000_AAAA});
        check("req021_conflict", XLEN'(bus.wr_conflict), 32'd1);
        step(1'b0, 3'b010, {5'd0, 5'd9, 5'd0}, 2'b00, 10'd0, 64'd0);
        check("req021_data", bus.rd_data[63:32], 32'h0000_5555);
        check("req021_conflict_drop", XLEN'(bus.wr_conflict), 32'd0);

        // Writes to reg 0 on both ports: acked, ignored, no conflict.
        step(1'b0, 3'b100, {5'd0, 5'd0, 5'd0}, 2'b11, {5'd0, 5'd0}, {32'hFFFF_FFFF, 32'hFFFF_FFFF});
        check("req022_wr_ack", XLEN'(bus.wr_ack), 32'd3);
        step(1'b0, 3'b001, {5'd0, 5'd0, 5'd0}, 2'b00, 10'd0, 64'd0);
        check("req022_data", bus.rd_data[31:0], 32'd0);

        // Reset mid-stream overrides a same-edge write.
        step(1'b0, 3'b000, 15'd0, 2'b01, {5'd0, 5'd4}, {32'd0, 32'h0000_0077});
        step(1'b1, 3'b001, {5'd0, 5'd0, 5'd4}, 2'b01, {5'd0, 5'd4}, {32'd0, 32'h0000_0088});
        step(1'b0, 3'b001, {5'd0, 5'd0, 5'd4}, 2'b00, 10'd0, 64'd0);
        check("req023_data", bus.rd_data[31:0], 32'd0);
        check("req023_wr_ack", XLEN'(bus.wr_ack), 32'd0);

        // Random concurrent traffic over a narrow address window.
        for (int n = 0; n < 80; n++) begin
            rv = NUM_RD'($urandom);
            wv = NUM_WR'($urandom);
            for (int i = 0; i < NUM_RD; i++) ra[i*AW +: AW] = AW'($urandom_range(0, 7));
            for (int j = 0; j < NUM_WR; j++) begin
                wa[j*AW +: AW]     = AW'($urandom_range(0, 7));
                wd[j*XLEN +: XLEN] = $urandom;
            end
            step((n == 40), rv, ra, wv, wa, wd);
        end

        // Persistence: read back a stretch of registers after idle cycles.
        step(1'b0, 3'b000, 15'd0, 2'b00, 10'd0, 64'd0);
        step(1'b0, 3'b000, 15'd0, 2'b00, 10'd0, 64'd0);
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 3'b111, {AW'(k), AW'((k + 1) % 8), AW'((k + 2) % 8)}, 2'b00, 10'd0, 64'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
